// File: rtl/run_monitor.sv
// Run monitor: tracks one program run from Start to Halt or cycle-limit timeout,
// counting run cycles and per-channel events with saturating, sticky-flagged counters.
module run_monitor #(
  parameter int CW   = 16,
  parameter int NCH  = 4,
  parameter int TLIM = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_halt,
  input  logic [NCH-1:0]    i_event,
  output logic              o_ack,
  output logic              o_busy,
  output logic              o_timeout,
  output logic [CW-1:0]     o_cycle_ct,
  output logic [NCH*CW-1:0] o_evt_ct,
  output logic [NCH:0]      o_sat
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TOUT} state_t;

  // Value of the cycle counter on the edge before the limit is reached.
  localparam logic [CW-1:0] TLIM_M1 = (TLIM > 0) ? CW'(TLIM - 1) : '0;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_cycle_ct;
  logic [NCH-1:0][CW-1:0]   r_evt;
  logic [NCH:0]             r_sat;
  logic                     w_count;
  logic                     w_tlim_hit;
  logic [CW:0]              w_cyc_inc;
  logic [NCH-1:0][CW:0]     w_evt_inc;

  // Saturating increment; MSB of the result flags an attempted overflow.
  function automatic logic [CW:0] sat_inc(input logic [CW-1:0] v);
    if (&v) return {1'b1, v};
    return {1'b0, v + CW'(1)};
  endfunction

  assign w_count    = (r_state == RUN) && !i_start && !i_halt;
  assign w_tlim_hit = (TLIM > 0) && (r_cycle_ct == TLIM_M1);

  always_comb begin
    w_cyc_inc = sat_inc(r_cycle_ct);
    for (int i = 0; i < NCH; i++) begin
      w_evt_inc[i] = sat_inc(r_evt[i]);
    end
  end

  // Start wins over everything; Halt wins over the cycle limit.
  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = RUN;
    end else if (r_state == RUN) begin
      if (i_halt)          w_state_nxt = DONE;
      else if (w_tlim_hit) w_state_nxt = TOUT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cycle_ct <= '0;
      r_evt      <= '0;
      r_sat      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_start) begin
        r_cycle_ct <= '0;
        r_evt      <= '0;
        r_sat      <= '0;
      end else if (w_count) begin
        r_cycle_ct <= w_cyc_inc[CW-1:0];
        if (w_cyc_inc[CW]) r_sat[NCH] <= 1'b1;
        for (int i = 0; i < NCH; i++) begin
          if (i_event[i]) begin
            r_evt[i] <= w_evt_inc[i][CW-1:0];
            if (w_evt_inc[i][CW]) r_sat[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign o_busy     = (r_state == RUN);
  assign o_ack      = (r_state == DONE) || (r_state == TOUT);
  assign o_timeout  = (r_state == TOUT);
  assign o_cycle_ct = r_cycle_ct;
  assign o_evt_ct   = r_evt;
  assign o_sat      = r_sat;

endmodule
